// File: rtl/pgm_tx_meter_if.sv
// Bus bundle for pgm_tx_meter: generator data path in/out, control ring in/out, timestamp.
// Handshakes: a *_wr strobe qualifies its data word in that cycle only (no per-word ready);
// flow control is level-based: out_tx_alf/in_tx_alf are almost-full hints, cout_tx_ready mirrors cin_tx_ready.
interface pgm_tx_meter_if;
    logic [133:0] in_tx_data;
    logic         in_tx_data_wr;
    logic         out_tx_alf;
    logic [133:0] out_tx_data;
    logic         out_tx_data_wr;
    logic         out_tx_valid;
    logic         out_tx_valid_wr;
    logic         in_tx_alf;
    logic [31:0]  timestamp2tx;
    logic [133:0] cin_tx_data;
    logic         cin_tx_data_wr;
    logic         cout_tx_ready;
    logic [133:0] cout_tx_data;
    logic         cout_tx_data_wr;
    logic         cin_tx_ready;
    logic [1:0]   dbg_state;

    modport slave (
        input  in_tx_data, in_tx_data_wr, in_tx_alf, timestamp2tx,
               cin_tx_data, cin_tx_data_wr, cin_tx_ready,
        output out_tx_alf, out_tx_data, out_tx_data_wr, out_tx_valid, out_tx_valid_wr,
               cout_tx_ready, cout_tx_data, cout_tx_data_wr, dbg_state
    );

    modport master (
        output in_tx_data, in_tx_data_wr, in_tx_alf, timestamp2tx,
               cin_tx_data, cin_tx_data_wr, cin_tx_ready,
        input  out_tx_alf, out_tx_data, out_tx_data_wr, out_tx_valid, out_tx_valid_wr,
               cout_tx_ready, cout_tx_data, cout_tx_data_wr, dbg_state
    );
endinterface

// File: rtl/pgm_tx_meter.sv
// Packet TX meter: framing-checked FIFO, drop-on-overflow, packet/byte counters read over cin/cout.
// Optional PGM_TX_METER_GAP_EN adds max inter-head timestamp gap at register 0x7.
module pgm_tx_meter #(
    parameter logic [7:0] LMID       = 8'd63,
    parameter int         FIFO_AW    = 6,
    parameter int         ALF_MARGIN = 8
) (
    input  logic          clk,
    input  logic          rst,
    pgm_tx_meter_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] ALF_LVL  = (FIFO_AW + 1)'(DEPTH - ALF_MARGIN);
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_BODY = 2'b11;
    localparam logic [1:0] T_TAIL = 2'b10;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BODY = 2'd1, S_DROP = 2'd2} in_state_t;

    in_state_t          state, state_nxt;
    logic [133:0]       mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, pop, push, push_req, drop_inc, frame_err_inc;
    logic [1:0]         in_type;
    logic [133:0]       pop_word;
    logic [63:0]        pop_bytes;
    logic [63:0]        pkt_cnt, byte_cnt;
    logic [31:0]        drop_cnt, frame_err_cnt;
    logic               soft_clr;

    assign in_type        = bus.in_tx_data[133:132];
    assign full           = (count == FULL_LVL);
    assign empty          = (count == '0);
    assign pop            = !empty && !bus.in_tx_alf;
    assign pop_word       = mem[rd_ptr];
    assign bus.out_tx_alf = (count >= ALF_LVL);
    assign bus.dbg_state  = state;

    // A push is refused only when the FIFO is full and no pop frees a slot this cycle.
    always_comb begin
        state_nxt     = state;
        push_req      = 1'b0;
        push          = 1'b0;
        drop_inc      = 1'b0;
        frame_err_inc = 1'b0;
        if (bus.in_tx_data_wr) begin
            case (state)
                S_IDLE: begin
                    if (in_type == T_HEAD) push_req = 1'b1;
                    else                   frame_err_inc = 1'b1;
                end
                S_BODY: begin
                    if (in_type == T_HEAD) begin
                        frame_err_inc = 1'b1;
                        push_req      = 1'b1;
                    end else if (in_type == T_BODY || in_type == T_TAIL) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err_inc = 1'b1;
                    end
                end
                S_DROP: begin
                    if (in_type == T_TAIL) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
            if (push_req) begin
                if (full && !pop) begin
                    drop_inc  = 1'b1;
                    state_nxt = (in_type == T_TAIL) ? S_IDLE : S_DROP;
                end else begin
                    push      = 1'b1;
                    state_nxt = (in_type == T_TAIL) ? S_IDLE : S_BODY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_tx_data     <= '0;
            bus.out_tx_data_wr  <= 1'b0;
            bus.out_tx_valid    <= 1'b0;
            bus.out_tx_valid_wr <= 1'b0;
        end else begin
            bus.out_tx_data_wr  <= pop;
            bus.out_tx_valid    <= pop && (pop_word[133:132] == T_TAIL);
            bus.out_tx_valid_wr <= pop && (pop_word[133:132] == T_TAIL);
            if (pop) bus.out_tx_data <= pop_word;
        end
    end

    // Tail byte field of 0 means a full 16-byte word.
    always_comb begin
        pop_bytes = 64'd16;
        if (pop_word[133:132] == T_TAIL && pop_word[131:128] != 4'd0)
            pop_bytes = {60'd0, pop_word[131:128]};
    end

    always_ff @(posedge clk) begin
        if (rst || soft_clr) begin
            pkt_cnt       <= '0;
            byte_cnt      <= '0;
            drop_cnt      <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (pop && pop_word[133:132] == T_TAIL) pkt_cnt <= pkt_cnt + 64'd1;
            if (pop)           byte_cnt      <= byte_cnt + pop_bytes;
            if (drop_inc)      drop_cnt      <= drop_cnt + 32'd1;
            if (frame_err_inc) frame_err_cnt <= frame_err_cnt + 32'd1;
        end
    end

`ifdef PGM_TX_METER_GAP_EN
    logic [31:0] max_gap, last_head_ts, gap;
    logic        head_seen;

    assign gap = bus.timestamp2tx - last_head_ts;

    always_ff @(posedge clk) begin
        if (rst || soft_clr) begin
            max_gap      <= '0;
            last_head_ts <= '0;
            head_seen    <= 1'b0;
        end else if (pop && pop_word[133:132] == T_HEAD) begin
            last_head_ts <= bus.timestamp2tx;
            head_seen    <= 1'b1;
            if (head_seen && gap > max_gap) max_gap <= gap;
        end
    end
`else
    logic unused_ts;
    assign unused_ts = ^bus.timestamp2tx;
`endif

    // Control ring: 2-word packets; cin_pos=0 expects a head, 1 expects the tail.
    logic        cin_pos, suppress_tail, head_mine, cfg_wr, cfg_rd;
    logic [31:0] cin_addr, rd_data;
    logic [133:0] rsp_head;

    assign cin_addr          = bus.cin_tx_data[95:64];
    assign head_mine         = !cin_pos && (bus.cin_tx_data[103:96] == LMID);
    assign cfg_wr            = bus.cin_tx_data_wr && head_mine && (bus.cin_tx_data[126:124] == 3'b010);
    assign cfg_rd            = bus.cin_tx_data_wr && head_mine && (bus.cin_tx_data[126:124] == 3'b001);
    assign bus.cout_tx_ready = bus.cin_tx_ready;
    assign rsp_head = {bus.cin_tx_data[133:128], 4'b1011, bus.cin_tx_data[123:112],
                       bus.cin_tx_data[103:96], bus.cin_tx_data[111:104],
                       bus.cin_tx_data[95:32], rd_data};

    always_comb begin
        rd_data = 32'hffff_ffff;
        case (cin_addr)
            32'h0:   rd_data = 32'h0;
            32'h1:   rd_data = pkt_cnt[31:0];
            32'h2:   rd_data = pkt_cnt[63:32];
            32'h3:   rd_data = byte_cnt[31:0];
            32'h4:   rd_data = byte_cnt[63:32];
            32'h5:   rd_data = drop_cnt;
            32'h6:   rd_data = frame_err_cnt;
`ifdef PGM_TX_METER_GAP_EN
            32'h7:   rd_data = max_gap;
`endif
            32'h8:   rd_data = 32'(count);
            default: rd_data = 32'hffff_ffff;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cin_pos             <= 1'b0;
            suppress_tail       <= 1'b0;
            soft_clr            <= 1'b0;
            bus.cout_tx_data    <= '0;
            bus.cout_tx_data_wr <= 1'b0;
        end else begin
            soft_clr            <= cfg_wr && (cin_addr == 32'h0) && bus.cin_tx_data[0];
            bus.cout_tx_data_wr <= 1'b0;
            if (bus.cin_tx_data_wr) begin
                cin_pos <= ~cin_pos;
                if (!cin_pos) begin
                    suppress_tail       <= cfg_wr;
                    bus.cout_tx_data_wr <= !cfg_wr;
                    bus.cout_tx_data    <= cfg_rd ? rsp_head : bus.cin_tx_data;
                end else begin
                    suppress_tail       <= 1'b0;
                    bus.cout_tx_data_wr <= !suppress_tail;
                    bus.cout_tx_data    <= bus.cin_tx_data;
                end
            end
        end
    end
endmodule
